rf_write_scheduler: RTL

//  Owns the single write port of RegFile: (WriteEn, Waddr, DataIn).

---
 rtl/rf_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 62 ++++++
 rtl/rf_write_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rf_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_sched_pkg
//  Description : Shared types and helpers for the RegFile write scheduler.
//                rf_sched_state_t  - scheduler FSM state (IDLE/CLEAR/DONE)
//                idx_width()       - index width for an N-entry select,
//                                    never less than 1 bit
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } rf_sched_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. The search for a requester starts at the
//                pointer and wraps mod N. The pointer moves one past the
//                winner, and only when Enable is high and a grant is made.
//  Ports       : Clk      in   clock
//                Reset    in   synchronous, active-low reset
//                Req      in   N   request vector
//                Enable   in   1   grants may be issued this cycle
//                Grant    out  N   one-hot grant; zero when disabled or idle
//                GrantIdx out  IW  index of the winning requester
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rf_sched_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [N-1:0]  Req,
    input  logic          Enable,
    output logic [N-1:0]  Grant,
    output logic [IW-1:0] GrantIdx
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_cand [N];
    logic [IW-1:0] w_idx;
    logic          w_found;

    // Candidate k in search order is (ptr + k) mod N.
    for (genvar k = 0; k < N; k++) begin : g_cand
        assign w_cand[k] = IW'((int'(r_ptr) + k) % N);
    end

    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && Req[w_cand[k]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[k];
            end
        end
    end

    assign Grant    = (Enable && w_found) ? (N'(1) << w_idx) : '0;
    assign GrantIdx = w_idx;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_ptr <= '0;
        end else if (Enable && w_found) begin
            r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_scheduler
//  Description : Owns the single RegFile write port. It round-robin arbitrates
//                N valid/ready write requesters, and it runs a clear sequencer
//                that zeroes all 2**A registers on command. The port outputs
//                are registered, so an accepted write appears one cycle after
//                its handshake.
//  Ports       : Clk, Reset        clock; synchronous active-low reset
//                ReqValid/ReqReady N    requester handshake
//                ReqAddr           N*A  packed requester addresses
//                ReqData           N*W  packed requester data
//                ClearStart        in   start full-file clear (IDLE only)
//                ClearBusy         out  sequencer not idle
//                ClearDone         out  pulse with the last clear write
//                WriteEn/Waddr/DataIn   RegFile write port
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int W = 8,
    parameter int A = 2,
    parameter int N = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [N-1:0]   ReqValid,
    input  logic [N*A-1:0] ReqAddr,
    input  logic [N*W-1:0] ReqData,
    output logic [N-1:0]   ReqReady,
    input  logic           ClearStart,
    output logic           ClearBusy,
    output logic           ClearDone,
    output logic           WriteEn,
    output logic [A-1:0]   Waddr,
    output logic [W-1:0]   DataIn
);

    localparam int             IW          = idx_width(N);
    localparam logic [A-1:0]   c_LAST_ADDR = '1;

    rf_sched_state_t r_state;
    rf_sched_state_t w_state_nxt;
    logic [A-1:0]    r_cnt;
    logic            r_we;
    logic [A-1:0]    r_waddr;
    logic [W-1:0]    r_data;

    logic            w_arb_en;
    logic [N-1:0]    w_grant;
    logic [IW-1:0]   w_grant_idx;
    logic [A-1:0]    w_req_addr [N];
    logic [W-1:0]    w_req_data [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign w_req_addr[i] = ReqAddr[i*A +: A];
        assign w_req_data[i] = ReqData[i*W +: W];
    end

    // A clear request in IDLE takes priority over every requester, and the
    // reset term keeps ReqReady low while Reset is asserted.
    assign w_arb_en = Reset && (r_state == IDLE) && !ClearStart;

    rr_arbiter #(
        .N        (N)
    ) u_arb (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (ReqValid),
        .Enable   (w_arb_en),
        .Grant    (w_grant),
        .GrantIdx (w_grant_idx)
    );

    assign ReqReady = w_grant;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (ClearStart) w_state_nxt = CLEAR;
            CLEAR:   if (r_cnt == c_LAST_ADDR) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output registers and clear counter. Waddr/DataIn hold whenever no
    // write is loaded.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_we    <= 1'b1;
                        r_waddr <= w_req_addr[w_grant_idx];
                        r_data  <= w_req_data[w_grant_idx];
                    end else begin
                        r_we    <= 1'b0;
                    end
                end
                CLEAR: begin
                    r_we    <= 1'b1;
                    r_waddr <= r_cnt;
                    r_data  <= '0;
                    r_cnt   <= (r_cnt == c_LAST_ADDR) ? '0 : r_cnt + 1'b1;
                end
                default: begin
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign WriteEn   = r_we;
    assign Waddr     = r_waddr;
    assign DataIn    = r_data;
    assign ClearBusy = (r_state != IDLE);
    assign ClearDone = (r_state == DONE);

endmodule
`default_nettype wire
